adsr_envelope_poly: RTL and testbench
=====================================

Name: adsr_envelope_poly

Overview:
- Polyphonic, parametrised ADSR envelope generator: one independent envelope per voice.
- All voices share one clock, one prescaler and one set of A/D/S/R settings; gain_in and key_held are per voice.
- Sits between the key scanner/voice allocator and the per-voice gain multiplier.
- Adds over the single-voice generator: legato retrigger from the current level, gain_in clamping, live sustain tracking, and a configurable time base.

Parameters:
- VOICES, 4, number of independent envelopes.
- GAIN_W, 13, gain_out width per voice; must be ≥ 5.
- TICK_DIV, 1, clocks per prescaler tick (50000 = 1 ms at 50 MHz); must be ≥ 1.
- CNT_W, 16, step-counter width; must be ≥ 15.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- key_held  in  VOICES  bit v = key for voice v held.
- gain_in  in  4*VOICES  per-voice peak multiplier 0-15; voice v at [4v+3:4v].
- attack  in  4  rate 0-15.
- decay  in  4  rate 0-15.
- sustain  in  4  level 0-15.
- release  in  4  rate 0-15.
- gain_out  out  GAIN_W*VOICES  per-voice envelope gain, registered.
- phase  out  3*VOICES  per-voice state code.
- env_done  out  VOICES  high while the voice is IDLE.

Behaviour:
- Reset values: gain_out=0, phase=IDLE (0), env_done=all 1s, prescaler=0, step counters=0. Reset applied mid-envelope returns to these values on the next edge.
- Prescaler: free-running 0..TICK_DIV-1. tick=1 when the count is TICK_DIV-1. With TICK_DIV=1, tick is constantly 1.
- Per-voice levels:
  - peak = gain_in<<(GAIN_W-4).
  - sus = (peak*sustain)/15, computed at width GAIN_W+4 and truncated to GAIN_W.
- Step rule for rate r≠0:
  - Step counter increments on each tick while the voice is in ATTACK, DECAY or RELEASE.
  - When counter==(1<<r)-1 and tick=1: gain moves by one LSB and the counter clears.
  - Step interval is therefore TICK_DIV*2^r clocks.
  - Counter clears on every state change.
- States (phase codes): IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4.
- IDLE:
  - gain=0, env_done=1.
  - key_held=1 → ATTACK next cycle; env_done drops in that same cycle.
- ATTACK:
  - attack==0 → gain=peak, go to DECAY.
  - Otherwise: step up. When stepped gain would be ≥peak: gain=peak, go to DECAY.
  - If gain>peak (gain_in lowered): gain=peak, go to DECAY.
  - key released → RELEASE; release takes priority over all ATTACK rules.
- DECAY:
  - decay==0 or gain≤sus → gain=sus, go to SUSTAIN.
  - Otherwise: step down, never below sus.
  - key released → RELEASE (priority).
- SUSTAIN:
  - gain=sus every cycle, tracking live sustain/gain_in changes.
  - key released → RELEASE.
- RELEASE:
  - release==0 → gain=0, go to IDLE.
  - Otherwise: step down. Reaching 0 → IDLE.
  - key_held=1 → ATTACK with gain retained (legato; no drop to 0).
- Latency: key edge sampled at cycle n → phase changes at n+1. Rate-0 jumps appear on gain_out at n+2.
- Arithmetic: gain never wraps. Down-steps floor at sus (DECAY) or 0 (RELEASE); up-steps cap at peak.
- Voices are fully independent; simultaneous edges on several voices are all honoured in the same cycle.
- sustain=15: sus=peak, so DECAY lasts one cycle. gain_in=0: ATTACK ends immediately, sus=0.

Optional Feature:
- Macro: ADSR_EXP_RELEASE_EN.
- Defined: each RELEASE step subtracts max(gain>>4, 1), giving an exponential tail that still reaches exactly 0.
- Undefined: RELEASE steps are linear, 1 LSB per step.
- ATTACK and DECAY are unaffected either way.

Decomposition:
- Package adsr_pkg:
  - phase localparams IDLE..RELEASE.
  - 3-bit phase typedef.
  - function sus_level(peak, sustain).
- Sub-module adsr_voice: one envelope FSM with its step counter, taking the shared tick. Instantiated VOICES times by a generate loop.
- Top level: holds the prescaler and the port slicing.

Test Plan:
- Reset and IDLE: reset=1 for 2 cycles, all keys 0 → gain_out=0, phase=0, env_done=all 1s. Assert reset mid-ATTACK → all voices back to IDLE, gain 0 on the next edge.
- Instant envelope: TICK_DIV=1, A=D=R=0, S=8, gain_in[0]=15, key0 rises at cycle 0 → phase ATTACK at 1, gain=7680/DECAY at 2, gain=4096/SUSTAIN at 3. Key released → gain=0 two cycles later, env_done=1.
- Linear attack timing: TICK_DIV=1, A=1, gain_in=1 → gain +1 every 2 clocks, reaches 512 after 1024 clocks of ATTACK, then enters DECAY.
- Legato retrigger: R=3, release at gain=7680; rekey at gain=7000 → phase ATTACK with gain continuing upward from 7000, no zero dip.
- Voice independence: voices 0 and 2 keyed on the same cycle, voice 2 released 100 cycles later → voice 0 unaffected. Voices 1 and 3 stay at 0 with env_done=1.
- Prescaler and clamp: TICK_DIV=4, A=2 → 16 clocks per step. Drop gain_in 15→4 mid-ATTACK at gain 3000 → next cycle gain=2048, phase DECAY.

Source files
------------

// File: rtl/adsr_pkg.sv
// Shared definitions for the polyphonic ADSR envelope generator:
// phase codes and the sustain-level helper.
package adsr_pkg;

  typedef enum logic [2:0] {
    PH_IDLE    = 3'd0,
    PH_ATTACK  = 3'd1,
    PH_DECAY   = 3'd2,
    PH_SUSTAIN = 3'd3,
    PH_RELEASE = 3'd4
  } phase_t;

  // peak*sustain/15; caller keeps GAIN_W+4 <= 32 so the product never overflows
  function automatic logic [31:0] sus_level(input logic [31:0] peak,
                                            input logic [3:0]  sustain);
    logic [31:0] prod;
    prod = peak * {28'd0, sustain};
    return prod / 32'd15;
  endfunction

endpackage

// File: rtl/adsr_voice.sv
// One ADSR envelope: phase FSM, gain register and step counter driven by the shared tick.
// ADSR_EXP_RELEASE_EN selects an exponential release tail instead of linear steps.
module adsr_voice
  import adsr_pkg::*;
#(
  parameter int GAIN_W = 13,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              tick_i,
  input  logic              key_i,
  input  logic [3:0]        gain_in_i,
  input  logic [3:0]        attack_i,
  input  logic [3:0]        decay_i,
  input  logic [3:0]        sustain_i,
  input  logic [3:0]        release_i,
  output logic [GAIN_W-1:0] gain_o,
  output logic [2:0]        phase_o,
  output logic              done_o
);

  phase_t            state_q, state_d;
  logic [GAIN_W-1:0] gain_q, gain_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              done_q;

  logic [GAIN_W-1:0] peak_s, sus_s, gain_up_s, dec_step_s;
  logic [CNT_W-1:0]  cnt_lim_s, cnt_adv_s;
  logic [3:0]        rate_s;
  logic              step_s;

  assign peak_s    = {gain_in_i, {(GAIN_W-4){1'b0}}};
  assign sus_s     = GAIN_W'(sus_level(32'(peak_s), sustain_i));
  assign gain_up_s = gain_q + GAIN_W'(1);

`ifdef ADSR_EXP_RELEASE_EN
  assign dec_step_s = (gain_q[GAIN_W-1:4] == '0) ? GAIN_W'(1) : (gain_q >> 4);
`else
  assign dec_step_s = GAIN_W'(1);
`endif

  // rate that governs the step counter in the current phase
  always_comb begin
    rate_s = 4'd0;
    case (state_q)
      PH_ATTACK:  rate_s = attack_i;
      PH_DECAY:   rate_s = decay_i;
      PH_RELEASE: rate_s = release_i;
      default:    rate_s = 4'd0;
    endcase
  end

  assign cnt_lim_s = (CNT_W'(1) << rate_s) - CNT_W'(1);
  assign step_s    = tick_i && (cnt_q == cnt_lim_s);
  assign cnt_adv_s = tick_i ? (cnt_q + CNT_W'(1)) : cnt_q;

  // phase transitions and gain update; key release/press always wins
  always_comb begin
    state_d = state_q;
    gain_d  = gain_q;
    cnt_d   = cnt_q;
    case (state_q)
      PH_IDLE: begin
        gain_d = '0;
        cnt_d  = '0;
        if (key_i) state_d = PH_ATTACK;
        else       state_d = PH_IDLE;
      end
      PH_ATTACK: begin
        if (!key_i) begin
          state_d = PH_RELEASE;
          cnt_d   = '0;
        end else if ((attack_i == 4'd0) || (gain_q >= peak_s)) begin
          gain_d  = peak_s;
          state_d = PH_DECAY;
          cnt_d   = '0;
        end else if (step_s) begin
          cnt_d = '0;
          if (gain_up_s >= peak_s) begin
            gain_d  = peak_s;
            state_d = PH_DECAY;
          end else begin
            gain_d = gain_up_s;
          end
        end else begin
          cnt_d = cnt_adv_s;
        end
      end
      PH_DECAY: begin
        if (!key_i) begin
          state_d = PH_RELEASE;
          cnt_d   = '0;
        end else if ((decay_i == 4'd0) || (gain_q <= sus_s)) begin
          gain_d  = sus_s;
          state_d = PH_SUSTAIN;
          cnt_d   = '0;
        end else if (step_s) begin
          cnt_d  = '0;
          gain_d = gain_q - GAIN_W'(1);
        end else begin
          cnt_d = cnt_adv_s;
        end
      end
      PH_SUSTAIN: begin
        cnt_d = '0;
        if (!key_i) state_d = PH_RELEASE;
        else        gain_d  = sus_s;
      end
      PH_RELEASE: begin
        if (key_i) begin
          // legato: climb again from wherever the release has got to
          state_d = PH_ATTACK;
          cnt_d   = '0;
        end else if ((release_i == 4'd0) || (gain_q == '0)) begin
          gain_d  = '0;
          state_d = PH_IDLE;
          cnt_d   = '0;
        end else if (step_s) begin
          cnt_d = '0;
          if (gain_q <= dec_step_s) begin
            gain_d  = '0;
            state_d = PH_IDLE;
          end else begin
            gain_d = gain_q - dec_step_s;
          end
        end else begin
          cnt_d = cnt_adv_s;
        end
      end
      default: begin
        state_d = PH_IDLE;
        gain_d  = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // state, gain, counter and done registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= PH_IDLE;
      gain_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      gain_q  <= gain_d;
      cnt_q   <= cnt_d;
      done_q  <= (state_d == PH_IDLE);
    end
  end

  assign gain_o  = gain_q;
  assign phase_o = state_q;
  assign done_o  = done_q;

endmodule

// File: rtl/adsr_envelope_poly.sv
// Polyphonic ADSR envelope generator: shared prescaler plus VOICES independent adsr_voice FSMs.
// Define ADSR_EXP_RELEASE_EN for an exponential release tail.
module adsr_envelope_poly
  import adsr_pkg::*;
#(
  parameter int VOICES   = 4,
  parameter int GAIN_W   = 13,
  parameter int TICK_DIV = 1,
  parameter int CNT_W    = 16
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [VOICES-1:0]        key_held_i,
  input  logic [4*VOICES-1:0]      gain_in_i,
  input  logic [3:0]               attack_i,
  input  logic [3:0]               decay_i,
  input  logic [3:0]               sustain_i,
  input  logic [3:0]               release_i,
  output logic [GAIN_W*VOICES-1:0] gain_out_o,
  output logic [3*VOICES-1:0]      phase_o,
  output logic [VOICES-1:0]        env_done_o
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0] pre_q, pre_d;
  logic          tick_s;

  assign tick_s = (pre_q == PW'(TICK_DIV - 1));

  // free-running prescaler, wraps at TICK_DIV-1
  always_comb begin
    if (tick_s) pre_d = '0;
    else        pre_d = pre_q + PW'(1);
  end

  // prescaler register
  always_ff @(posedge clk_i) begin
    if (reset_i) pre_q <= '0;
    else         pre_q <= pre_d;
  end

  for (genvar v = 0; v < VOICES; v++) begin : g_voice
    adsr_voice #(
      .GAIN_W (GAIN_W),
      .CNT_W  (CNT_W)
    ) u_voice (
      .clk_i     (clk_i),
      .reset_i   (reset_i),
      .tick_i    (tick_s),
      .key_i     (key_held_i[v]),
      .gain_in_i (gain_in_i[4*v +: 4]),
      .attack_i  (attack_i),
      .decay_i   (decay_i),
      .sustain_i (sustain_i),
      .release_i (release_i),
      .gain_o    (gain_out_o[GAIN_W*v +: GAIN_W]),
      .phase_o   (phase_o[3*v +: 3]),
      .done_o    (env_done_o[v])
    );
  end

endmodule

// File: tb/tb_adsr_envelope_poly.sv
// Scoreboard bench: two DUTs (TICK_DIV 1 and 4) on shared stimulus, checked against a behavioural model.
module tb_adsr_envelope_poly;

  localparam int V  = 4;
  localparam int GW = 13;

  logic            clk = 1'b0;
  logic            rst;
  logic [V-1:0]    key;
  logic [4*V-1:0]  gin;
  logic [3:0]      att, dcy, sus, rel;
  logic [GW*V-1:0] go0, go1;
  logic [3*V-1:0]  ph0, ph1;
  logic [V-1:0]    dn0, dn1;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];

  int m_ph[2][V];
  int m_g[2][V];
  int m_c[2][V];
  int m_p[2];
  int td[2] = '{1, 4};

  always #5 clk = ~clk;

  adsr_envelope_poly #(.VOICES(V), .GAIN_W(GW), .TICK_DIV(1), .CNT_W(16)) dut0 (
    .clk_i(clk), .reset_i(rst), .key_held_i(key), .gain_in_i(gin),
    .attack_i(att), .decay_i(dcy), .sustain_i(sus), .release_i(rel),
    .gain_out_o(go0), .phase_o(ph0), .env_done_o(dn0));

  adsr_envelope_poly #(.VOICES(V), .GAIN_W(GW), .TICK_DIV(4), .CNT_W(16)) dut1 (
    .clk_i(clk), .reset_i(rst), .key_held_i(key), .gain_in_i(gin),
    .attack_i(att), .decay_i(dcy), .sustain_i(sus), .release_i(rel),
    .gain_out_o(go1), .phase_o(ph1), .env_done_o(dn1));

  function automatic logic [31:0] act_val(input int i, input int v);
    logic [GW-1:0] g;
    logic [2:0]    p;
    logic          d;
    if (i == 0) begin
      g = go0[v*GW +: GW]; p = ph0[v*3 +: 3]; d = dn0[v];
    end else begin
      g = go1[v*GW +: GW]; p = ph1[v*3 +: 3]; d = dn1[v];
    end
    return {15'd0, g, p, d};
  endfunction

  function automatic logic [31:0] pack(input int g, input int ph);
    return 32'((g << 4) | (ph << 1) | ((ph == 0) ? 1 : 0));
  endfunction

  // Reference: envelope rules in plain integer arithmetic, one step per clock.
  task automatic model_step(input bit do_rst);
    for (int i = 0; i < 2; i++) begin
      bit tk;
      tk = (m_p[i] == td[i] - 1);
      for (int v = 0; v < V; v++) begin
        int pk, sl, rt, g, ph, c, dd;
        bit k, st;
        g = m_g[i][v]; ph = m_ph[i][v]; c = m_c[i][v];
        k  = key[v];
        pk = int'(gin[4*v +: 4]) * 512;
        sl = (pk * int'(sus)) / 15;
        rt = (ph == 1) ? int'(att) : (ph == 2) ? int'(dcy) : (ph == 4) ? int'(rel) : 0;
        st = tk && (c == (1 << rt) - 1);
`ifdef ADSR_EXP_RELEASE_EN
        dd = (g / 16 > 1) ? g / 16 : 1;
`else
        dd = 1;
`endif
        if (do_rst) begin
          g = 0; ph = 0; c = 0;
        end else if (ph == 0) begin
          g = 0; c = 0;
          if (k) ph = 1;
        end else if (ph == 1) begin
          if (!k) begin ph = 4; c = 0; end
          else if (att == 4'd0 || g >= pk) begin g = pk; ph = 2; c = 0; end
          else if (st) begin
            g = (g + 1 < pk) ? g + 1 : pk;
            if (g == pk) ph = 2;
            c = 0;
          end else c = tk ? c + 1 : c;
        end else if (ph == 2) begin
          if (!k) begin ph = 4; c = 0; end
          else if (dcy == 4'd0 || g <= sl) begin g = sl; ph = 3; c = 0; end
          else if (st) begin g = (g - 1 > sl) ? g - 1 : sl; c = 0; end
          else c = tk ? c + 1 : c;
        end else if (ph == 3) begin
          if (!k) begin ph = 4; c = 0; end
          else g = sl;
        end else begin
          if (k) begin ph = 1; c = 0; end
          else if (rel == 4'd0 || g == 0) begin g = 0; ph = 0; c = 0; end
          else if (st) begin
            g = (g - dd > 0) ? g - dd : 0;
            if (g == 0) ph = 0;
            c = 0;
          end else c = tk ? c + 1 : c;
        end
        m_g[i][v] = g; m_ph[i][v] = ph; m_c[i][v] = c;
      end
      m_p[i] = do_rst ? 0 : (m_p[i] + 1) % td[i];
    end
    for (int i = 0; i < 2; i++)
      for (int v = 0; v < V; v++)
        exp_q.push_back(pack(m_g[i][v], m_ph[i][v]));
  endtask

  // apply the current inputs for one clock; returns just after the edge
  task automatic cycle(input bit do_rst);
    rst = do_rst;
    model_step(do_rst);
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int j = 0; j < n; j++) cycle(1'b0);
  endtask

  task automatic spot(input string nm, input int i, input int v, input int eg, input int eph);
    logic [31:0] a, e;
    a = act_val(i, v);
    e = pack(eg, eph);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s inst%0d voice%0d: got gain=%0d phase=%0d done=%0d, want gain=%0d phase=%0d done=%0d",
               nm, i, v, a[31:4], a[3:1], a[0], e[31:4], e[3:1], e[0]);
    end
  endtask

  // monitor: each clock the DUTs present a fresh output word per voice
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() >= 2*V) begin
        for (int i = 0; i < 2; i++) begin
          for (int v = 0; v < V; v++) begin
            logic [31:0] e, a;
            e = exp_q.pop_front();
            a = act_val(i, v);
            n_cmp++;
            if (a !== e) begin
              n_bad++;
              $display("FAIL sb inst%0d voice%0d t=%0t: got gain=%0d phase=%0d done=%0d, want gain=%0d phase=%0d done=%0d",
                       i, v, $time, a[31:4], a[3:1], a[0], e[31:4], e[3:1], e[0]);
            end
          end
        end
      end
    end
  end

  initial begin
    int guard;
    key = '0; gin = '0; att = 4'd0; dcy = 4'd0; sus = 4'd8; rel = 4'd0; rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      m_p[i] = 0;
      for (int v = 0; v < V; v++) begin m_g[i][v] = 0; m_ph[i][v] = 0; m_c[i][v] = 0; end
    end

    // reset and idle
    cycle(1'b1); cycle(1'b1);
    for (int v = 0; v < V; v++) spot("reset", 0, v, 0, 0);
    run(2);

    // instant envelope
    gin[3:0] = 4'd15;
    key = 4'b0001; cycle(1'b0); spot("inst_atk", 0, 0, 0, 1);
    cycle(1'b0); spot("inst_peak", 0, 0, 7680, 2);
    cycle(1'b0); spot("inst_sus", 0, 0, 4096, 3);
    key = 4'b0000; cycle(1'b0); spot("inst_rel", 0, 0, 4096, 4);
    cycle(1'b0); spot("inst_idle", 0, 0, 0, 0);
    run(2);

    // linear attack, one LSB every two clocks
    gin[3:0] = 4'd1; att = 4'd1;
    key = 4'b0001; cycle(1'b0);
    run(1023); spot("lin_511", 0, 0, 511, 1);
    cycle(1'b0); spot("lin_peak", 0, 0, 512, 2);
    cycle(1'b0); spot("lin_sus", 0, 0, 273, 3);
    key = 4'b0000; run(3);

    // legato retrigger from the release tail
    gin[3:0] = 4'd15; att = 4'd0; dcy = 4'd15; sus = 4'd8;
    key = 4'b0001; run(3);
    spot("leg_peak", 0, 0, 7680, 2);
    rel = 4'd3; key = 4'b0000; cycle(1'b0); spot("leg_rel", 0, 0, 7680, 4);
    guard = 0;
    while (m_g[0][0] > 7000 && guard < 8000) begin cycle(1'b0); guard++; end
    n_cmp++;
    if (m_g[0][0] != 7000) begin
      n_bad++;
      $display("FAIL leg_wait: release reached gain=%0d, wanted 7000 within budget", m_g[0][0]);
    end
    att = 4'd3; key = 4'b0001; cycle(1'b0); spot("leg_retrig", 0, 0, 7000, 1);
    run(16); spot("leg_climb", 0, 0, 7002, 1);
    run(84);
    rel = 4'd0; key = 4'b0000; run(3);

    // voice independence
    gin = {4'd15, 4'd15, 4'd15, 4'd15}; att = 4'd2; dcy = 4'd2; sus = 4'd10; rel = 4'd2;
    key = 4'b0101; run(100);
    key = 4'b0001; run(100);
    spot("indep_v1", 0, 1, 0, 0);
    spot("indep_v3", 0, 3, 0, 0);
    rel = 4'd0; key = 4'b0000; run(3);

    // reset mid-attack
    att = 4'd4; key = 4'b1111; run(50);
    cycle(1'b1);
    for (int v = 0; v < V; v++) begin
      spot("rst_mid0", 0, v, 0, 0);
      spot("rst_mid1", 1, v, 0, 0);
    end
    key = 4'b0000; run(2);

    // prescaler and gain_in clamp on the TICK_DIV=4 instance
    gin = {4'd0, 4'd0, 4'd0, 4'd15}; att = 4'd0; dcy = 4'd0; sus = 4'd6;
    key = 4'b0001; run(4);
    spot("clamp_sus", 1, 0, 3072, 3);
    rel = 4'd1; key = 4'b0000;
    guard = 0;
    while (m_g[1][0] > 3000 && guard < 2000) begin cycle(1'b0); guard++; end
    n_cmp++;
    if (m_g[1][0] != 3000) begin
      n_bad++;
      $display("FAIL clamp_wait: release reached gain=%0d, wanted 3000 within budget", m_g[1][0]);
    end
    att = 4'd2; key = 4'b0001; cycle(1'b0); spot("clamp_retrig", 1, 0, 3000, 1);
    run(40);
    gin[3:0] = 4'd4; cycle(1'b0); spot("clamp_2048", 1, 0, 2048, 2);
    rel = 4'd0; key = 4'b0000; run(3);

    // randomized traffic
    for (int j = 0; j < 3000; j++) begin
      if (j % 200 == 0) begin
        att = 4'($urandom_range(0, 4)); dcy = 4'($urandom_range(0, 4));
        rel = 4'($urandom_range(0, 4)); sus = 4'($urandom_range(0, 15));
        gin = 16'($urandom);
      end
      if (j % 37 == 0) sus = 4'($urandom_range(0, 15));
      for (int v = 0; v < V; v++)
        if ($urandom_range(0, 31) == 0) key[v] = ~key[v];
      cycle(1'b0);
    end
    key = 4'b0000; rel = 4'd0; run(3);

    @(negedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expected words left unchecked, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
